fetch_redirect_ctrl: RTL

Sequencing controller for the instruction-fetch PC path. Consumes the static branch predictor's decode (taken-prediction for JAL/branches, JALR flag) plus resolution from execute, and drives the next-PC value, PC write enable and fetch/decode kill signals. It sits between the branch predictor, the PC register and the IF/ID and ID/EX pipeline registers. A small FSM handles JALR stalls and the one-cycle post-redirect bubble.

---
 rtl/fetch_ctrl_pkg.sv | 19 +
 rtl/sat_counter.sv | 42 ++++
 rtl/fetch_redirect_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_pkg.sv
//----------------------------------------------------------------------
// fetch_ctrl_pkg : shared types and constants for the fetch redirect path
// Revision: 1.0
//----------------------------------------------------------------------
`default_nettype none

package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    JALR_WAIT = 2'd1,
    REDIRECT  = 2'd2
  } fetch_state_e;

  localparam int unsigned INSTR_BYTES = 4;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
//----------------------------------------------------------------------
// sat_counter : up-counter with synchronous clear, holds at MAX
// Revision: 1.0
//----------------------------------------------------------------------
`default_nettype none

module sat_counter #(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/fetch_redirect_ctrl.sv
//----------------------------------------------------------------------
// fetch_redirect_ctrl : next-PC / kill sequencing for JALR stalls and
// redirects. Optional statistics counters under FETCH_STATS_EN.
// Revision: 1.0
//----------------------------------------------------------------------
`default_nettype none

module fetch_redirect_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int SIZE          = 32,
  parameter int JALR_MAX_WAIT = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  input  logic [SIZE-1:0] if_pc,
  input  logic            pred_taken,
  input  logic            pred_jalr,
  input  logic [SIZE-1:0] pred_target,
  input  logic            ex_valid,
  input  logic            ex_mispredict,
  input  logic            ex_jalr,
  input  logic [SIZE-1:0] ex_target,
  output logic [SIZE-1:0] pc_next,
  output logic            pc_write,
  output logic            if_kill,
  output logic            id_kill,
  output logic            jalr_timeout,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
);

  localparam int CW = $clog2(JALR_MAX_WAIT + 1);

  fetch_state_e    state_q, state_d;
  logic [CW-1:0]   wait_cnt;
  logic            wait_clr, wait_inc;
  logic            timeout_q, timeout_d;
  logic            redirect;
  logic [SIZE-1:0] pc_plus4;

  assign redirect = ex_valid & (ex_mispredict | ex_jalr);
  assign pc_plus4 = if_pc + SIZE'(INSTR_BYTES);

  always_comb begin
    state_d   = state_q;
    pc_next   = pc_plus4;
    pc_write  = 1'b0;
    if_kill   = 1'b0;
    id_kill   = 1'b0;
    wait_clr  = 1'b0;
    wait_inc  = 1'b0;
    timeout_d = timeout_q;

    // A resolved redirect from EX overrides every state.
    if (redirect) begin
      pc_next  = ex_target;
      pc_write = 1'b1;
      if_kill  = 1'b1;
      id_kill  = 1'b1;
      state_d  = REDIRECT;
    end else begin
      case (state_q)
        RUN: begin
          if (if_valid && pred_jalr) begin
            wait_clr = 1'b1;
            state_d  = JALR_WAIT;
          end else if (if_valid && pred_taken) begin
            pc_next  = pred_target;
            pc_write = 1'b1;
          end else begin
            pc_write = if_valid;
          end
        end
        JALR_WAIT: begin
          if_kill  = 1'b1;
          wait_inc = 1'b1;
          if (wait_cnt >= CW'(JALR_MAX_WAIT - 1)) begin
            timeout_d = 1'b1;
          end
        end
        REDIRECT: begin
          if_kill  = 1'b1;
          pc_write = if_valid;
          state_d  = RUN;
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timeout_q <= timeout_d;
    end
  end

  sat_counter #(
    .WIDTH (CW),
    .MAX   (CW'(JALR_MAX_WAIT))
  ) u_wait_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (wait_clr),
    .inc_i   (wait_inc),
    .count_o (wait_cnt)
  );

  assign jalr_timeout = timeout_q;

`ifdef FETCH_STATS_EN
  sat_counter #(
    .WIDTH (32)
  ) u_stat_br (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (1'b0),
    .inc_i   (ex_valid),
    .count_o (stat_branches)
  );

  sat_counter #(
    .WIDTH (32)
  ) u_stat_mp (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (1'b0),
    .inc_i   (redirect),
    .count_o (stat_mispredicts)
  );
`else
  assign stat_branches    = 32'd0;
  assign stat_mispredicts = 32'd0;
`endif

endmodule

`default_nettype wire
